// File: rtl/fpga2host_pkg.sv
// Shared types and constants for the fpga2host packet arbiter.
// Optional build macro: FPGA2HOST_ARB_PRIO_EN (strict priority for source 0).
package fpga2host_pkg;

   localparam int         WORD_W      = 32;
   localparam logic [7:0] HDR_TAG_DEF = 8'hA5;
   localparam int         HDR_TAG_LSB = 24;
   localparam int         HDR_SRC_LSB = 16;
   localparam int         HDR_SEQ_LSB = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_DROP
   } arb_state_t;

   function automatic logic [WORD_W-1:0] make_hdr(
      input logic [7:0]  tag,
      input logic [7:0]  src,
      input logic [15:0] seq
   );
      logic [WORD_W-1:0] w;
      w = '0;
      w[HDR_TAG_LSB +: 8]  = tag;
      w[HDR_SRC_LSB +: 8]  = src;
      w[HDR_SEQ_LSB +: 16] = seq;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request at or after the
// pointer, wrapping cyclically.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_idx,
   output logic          o_found
);

   logic [IW-1:0] w_j;

   // Walk from the far end so the closest request to the pointer wins.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_j     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_j = IW'((int'(i_ptr) + k) % N);
         if (i_req[w_j]) begin
            o_found = 1'b1;
            o_idx   = w_j;
         end
      end
   end

endmodule

// File: rtl/fpga2host_arbiter.sv
// Packet arbiter feeding the fpga2host stream; prefixes each packet with a
// header. Build macro FPGA2HOST_ARB_PRIO_EN gives source 0 strict priority.
module fpga2host_arbiter
   import fpga2host_pkg::*;
#(
   parameter int         NUM_SRC       = 3,
   parameter int         MAX_PKT_WORDS = 256,
   parameter logic [7:0] HDR_TAG       = HDR_TAG_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SRC-1:0]              s_tvalid,
   input  logic [NUM_SRC-1:0][WORD_W-1:0]  s_tdata,
   input  logic [NUM_SRC-1:0]              s_tlast,
   output logic [NUM_SRC-1:0]              s_tready,
   output logic                            m_tvalid,
   output logic [WORD_W-1:0]               m_tdata,
   output logic                            m_tlast,
   input  logic                            m_tready,
   output logic                            err_trunc_pulse
);

   localparam int IW = $clog2(NUM_SRC);
   localparam int CW = $clog2(MAX_PKT_WORDS + 1);

   arb_state_t        r_state, w_nstate;
   logic [IW-1:0]     r_gnt, r_rr, w_pick, w_nxt_rr;
   logic              w_found;
   logic [15:0]       r_seq;
   logic [CW-1:0]     r_wcnt;
   logic              r_mvalid, r_mlast, r_err;
   logic [WORD_W-1:0] r_mdata;
   logic              w_free, w_gvalid, w_glast, w_ld_hdr;
   logic              w_acc_data, w_acc_drop, w_at_max, w_trunc, w_eop;

`ifdef FPGA2HOST_ARB_PRIO_EN
   logic [IW-1:0] w_rr_idx;
   logic          w_rr_found;

   rr_pick #(.N(NUM_SRC)) u_pick (
      .i_req   (s_tvalid & ~NUM_SRC'(1)),
      .i_ptr   (r_rr),
      .o_idx   (w_rr_idx),
      .o_found (w_rr_found)
   );

   assign w_pick   = s_tvalid[0] ? '0 : w_rr_idx;
   assign w_found  = s_tvalid[0] | w_rr_found;
   // Source 0 never needs the pointer, so skip over it on wrap.
   assign w_nxt_rr = (r_gnt == IW'(NUM_SRC - 1)) ? IW'(1) : r_gnt + 1'b1;
`else
   rr_pick #(.N(NUM_SRC)) u_pick (
      .i_req   (s_tvalid),
      .i_ptr   (r_rr),
      .o_idx   (w_pick),
      .o_found (w_found)
   );

   assign w_nxt_rr = (r_gnt == IW'(NUM_SRC - 1)) ? '0 : r_gnt + 1'b1;
`endif

   assign w_free     = !r_mvalid || m_tready;
   assign w_gvalid   = s_tvalid[r_gnt];
   assign w_glast    = s_tlast[r_gnt];
   assign w_at_max   = (r_wcnt == CW'(MAX_PKT_WORDS - 1));
   assign w_ld_hdr   = (r_state == S_HDR) && w_free;
   assign w_acc_data = (r_state == S_DATA) && w_free && w_gvalid;
   assign w_acc_drop = (r_state == S_DROP) && w_gvalid;
   assign w_trunc    = w_acc_data && !w_glast && w_at_max;
   assign w_eop      = (w_acc_data || w_acc_drop) && w_glast;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      unique case (r_state)
         S_IDLE: if (w_found) w_nstate = S_HDR;
         S_HDR:  if (w_free)  w_nstate = S_DATA;
         S_DATA: begin
            if (w_eop)        w_nstate = S_IDLE;
            else if (w_trunc) w_nstate = S_DROP;
         end
         S_DROP: if (w_eop)   w_nstate = S_IDLE;
      endcase
   end

   always_comb begin
      s_tready = '0;
      if ((r_state == S_DATA && w_free) || r_state == S_DROP)
         s_tready[r_gnt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt    <= '0;
         r_rr     <= '0;
         r_seq    <= '0;
         r_wcnt   <= '0;
         r_mvalid <= 1'b0;
         r_mlast  <= 1'b0;
         r_mdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= w_trunc;
         if (r_state == S_IDLE) begin
            r_wcnt <= '0;
            if (w_found) r_gnt <= w_pick;
         end
         if (w_eop) r_rr <= w_nxt_rr;
         if (w_ld_hdr) begin
            r_mvalid <= 1'b1;
            r_mlast  <= 1'b0;
            r_mdata  <= make_hdr(HDR_TAG, 8'(r_gnt), r_seq);
            r_seq    <= r_seq + 16'd1;
         end else if (w_acc_data) begin
            r_mvalid <= 1'b1;
            r_mlast  <= w_glast || w_at_max;
            r_mdata  <= s_tdata[r_gnt];
            r_wcnt   <= r_wcnt + 1'b1;
         end else if (m_tready) begin
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
         end
      end
   end

   assign m_tvalid        = r_mvalid;
   assign m_tdata         = r_mdata;
   assign m_tlast         = r_mlast;
   assign err_trunc_pulse = r_err;

endmodule

// File: tb/tb_fpga2host_arbiter.sv
// Scoreboard bench for fpga2host_arbiter (3 sources, 4-word max packets).
// Expectations follow FPGA2HOST_ARB_PRIO_EN when it is defined.
module tb_fpga2host_arbiter;
   import fpga2host_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        s_tvalid, s_tlast, s_tready;
   logic [2:0][31:0]  s_tdata;
   logic              m_tvalid, m_tlast, m_tready, err_trunc_pulse;
   logic [31:0]       m_tdata;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                err_cnt  = 0;
   int                seq_exp  = 0;
   logic [32:0]       exp_q[$];
   logic [32:0]       sq[3][$];
   logic [2:0]        acc;
   logic              prev_stall = 1'b0;
   logic              prev_err   = 1'b0;
   logic [32:0]       prev_word  = '0;

   always #5 clk = ~clk;

   fpga2host_arbiter #(
      .NUM_SRC       (3),
      .MAX_PKT_WORDS (4),
      .HDR_TAG       (8'hA5)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s_tvalid        (s_tvalid),
      .s_tdata         (s_tdata),
      .s_tlast         (s_tlast),
      .s_tready        (s_tready),
      .m_tvalid        (m_tvalid),
      .m_tdata         (m_tdata),
      .m_tlast         (m_tlast),
      .m_tready        (m_tready),
      .err_trunc_pulse (err_trunc_pulse)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_hdr(input int src);
      exp_q.push_back({1'b0, 8'hA5, 8'(src), 16'(seq_exp)});
      seq_exp++;
   endtask

   task automatic exp_word(input logic last, input logic [31:0] d);
      exp_q.push_back({last, d});
   endtask

   task automatic src_word(input int s, input logic last, input logic [31:0] d);
      sq[s].push_back({last, d});
   endtask

   task automatic wait_drain(input string name, input logic toggle);
      int i;
      for (i = 0; i < 300; i++) begin
         @(posedge clk); #2;
         m_tready = toggle ? !m_tready : 1'b1;
         @(negedge clk);
         if (exp_q.size() == 0 && sq[0].size() == 0 && sq[1].size() == 0 &&
             sq[2].size() == 0 && !m_tvalid)
            break;
      end
      check({name, "_drain"}, 32'(i < 300), 32'd1);
      m_tready = 1'b1;
   endtask

   // Source drivers: present queue heads, pop on accepted handshake.
   initial begin
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      forever begin
         @(negedge clk);
         acc = rst ? 3'b000 : (s_tvalid & s_tready);
         @(posedge clk); #1;
         for (int s = 0; s < 3; s++) begin
            if (acc[s] && sq[s].size() > 0) void'(sq[s].pop_front());
            if (sq[s].size() > 0) begin
               s_tvalid[s] = 1'b1;
               s_tdata[s]  = sq[s][0][31:0];
               s_tlast[s]  = sq[s][0][32];
            end else begin
               s_tvalid[s] = 1'b0;
               s_tdata[s]  = '0;
               s_tlast[s]  = 1'b0;
            end
         end
      end
   end

   // Output monitor and scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         prev_err   = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(m_tvalid), 32'd1);
            check("stall_data", m_tdata, prev_word[31:0]);
            check("stall_last", 32'(m_tlast), 32'(prev_word[32]));
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_out: got %h expected none", m_tdata);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               check("out_data", m_tdata, e[31:0]);
               check("out_last", 32'(m_tlast), 32'(e[32]));
            end
         end
         if (m_tvalid && !m_tready)
            check("tready_when_full", 32'(s_tready), 32'd0);
         if (err_trunc_pulse) begin
            err_cnt++;
            check("pulse_width", 32'(prev_err), 32'd0);
         end
         prev_stall = m_tvalid && !m_tready;
         prev_word  = {m_tlast, m_tdata};
         prev_err   = err_trunc_pulse;
      end
   end

   initial begin
      int n;
      int i;
      rst      = 1'b1;
      m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      @(negedge clk);
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_m_tlast", 32'(m_tlast), 32'd0);
      check("rst_m_tdata", m_tdata, 32'd0);
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_err", 32'(err_trunc_pulse), 32'd0);

      // Single packet from src1, header latency of 2 cycles.
      @(posedge clk); #2;
      src_word(1, 1'b0, 32'h11);
      src_word(1, 1'b0, 32'h22);
      src_word(1, 1'b1, 32'h33);
      exp_hdr(1);
      exp_word(1'b0, 32'h11);
      exp_word(1'b0, 32'h22);
      exp_word(1'b1, 32'h33);
      for (i = 0; i < 10 && !s_tvalid[1]; i++) begin
         @(posedge clk); #2;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_tvalid && n < 10);
      check("hdr_latency", 32'(n), 32'd3);
      check("first_hdr", m_tdata, 32'hA501_0000);
      wait_drain("single", 1'b0);

      // Exact length: 4 words ending on the limit, seq continues at 1.
      src_word(2, 1'b0, 32'h21);
      src_word(2, 1'b0, 32'h22);
      src_word(2, 1'b0, 32'h23);
      src_word(2, 1'b1, 32'h24);
      exp_hdr(2);
      exp_word(1'b0, 32'h21);
      exp_word(1'b0, 32'h22);
      exp_word(1'b0, 32'h23);
      exp_word(1'b1, 32'h24);
      wait_drain("exact", 1'b0);
      check("exact_no_pulse", 32'(err_cnt), 32'd0);
      check("exact_idle", 32'(dut.r_state), 32'(S_IDLE));

      // All sources pending one-word packets.
      src_word(0, 1'b1, 32'hA0);
      src_word(0, 1'b1, 32'hA1);
      src_word(1, 1'b1, 32'hB0);
      src_word(1, 1'b1, 32'hB1);
      src_word(2, 1'b1, 32'hC0);
      src_word(2, 1'b1, 32'hC1);
`ifdef FPGA2HOST_ARB_PRIO_EN
      exp_hdr(0); exp_word(1'b1, 32'hA0);
      exp_hdr(0); exp_word(1'b1, 32'hA1);
      exp_hdr(1); exp_word(1'b1, 32'hB0);
      exp_hdr(2); exp_word(1'b1, 32'hC0);
      exp_hdr(1); exp_word(1'b1, 32'hB1);
      exp_hdr(2); exp_word(1'b1, 32'hC1);
`else
      exp_hdr(0); exp_word(1'b1, 32'hA0);
      exp_hdr(1); exp_word(1'b1, 32'hB0);
      exp_hdr(2); exp_word(1'b1, 32'hC0);
      exp_hdr(0); exp_word(1'b1, 32'hA1);
      exp_hdr(1); exp_word(1'b1, 32'hB1);
      exp_hdr(2); exp_word(1'b1, 32'hC1);
`endif
      wait_drain("round_robin", 1'b0);

      // Backpressure with m_tready toggling every cycle.
      src_word(0, 1'b0, 32'h40);
      src_word(0, 1'b0, 32'h41);
      src_word(0, 1'b0, 32'h42);
      src_word(0, 1'b1, 32'h43);
      exp_hdr(0);
      exp_word(1'b0, 32'h40);
      exp_word(1'b0, 32'h41);
      exp_word(1'b0, 32'h42);
      exp_word(1'b1, 32'h43);
      wait_drain("backpressure", 1'b1);
      check("bp_no_pulse", 32'(err_cnt), 32'd0);

      // Truncation: 6 words, only 4 forwarded.
      src_word(2, 1'b0, 32'h61);
      src_word(2, 1'b0, 32'h62);
      src_word(2, 1'b0, 32'h63);
      src_word(2, 1'b0, 32'h64);
      src_word(2, 1'b0, 32'h65);
      src_word(2, 1'b1, 32'h66);
      exp_hdr(2);
      exp_word(1'b0, 32'h61);
      exp_word(1'b0, 32'h62);
      exp_word(1'b0, 32'h63);
      exp_word(1'b1, 32'h64);
      wait_drain("trunc", 1'b0);
      check("trunc_pulse", 32'(err_cnt), 32'd1);
      check("trunc_idle", 32'(dut.r_state), 32'(S_IDLE));
      src_word(1, 1'b1, 32'h77);
      exp_hdr(1);
      exp_word(1'b1, 32'h77);
      wait_drain("after_trunc", 1'b0);
      check("after_trunc_pulse", 32'(err_cnt), 32'd1);

      // Reset after two data words of a packet.
      src_word(0, 1'b0, 32'h81);
      src_word(0, 1'b0, 32'h82);
      src_word(0, 1'b0, 32'h83);
      src_word(0, 1'b1, 32'h84);
      exp_hdr(0);
      exp_word(1'b0, 32'h81);
      exp_word(1'b0, 32'h82);
      exp_word(1'b0, 32'h83);
      exp_word(1'b1, 32'h84);
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_tvalid && m_tready && m_tdata == 32'h82) break;
      end
      check("rst_trigger", 32'(i < 50), 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      for (int s = 0; s < 3; s++) sq[s].delete();
      exp_q.delete();
      @(posedge clk); #2;
      @(negedge clk);
      check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("midrst_state", 32'(dut.r_state), 32'(S_IDLE));
      check("midrst_s_tready", 32'(s_tready), 32'd0);
      @(posedge clk); #2;
      rst     = 1'b0;
      seq_exp = 0;
      src_word(0, 1'b1, 32'h91);
      src_word(1, 1'b1, 32'h92);
      exp_hdr(0);
      exp_word(1'b1, 32'h91);
      exp_hdr(1);
      exp_word(1'b1, 32'h92);
      wait_drain("post_reset", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpga2host_arbiter.md
# fpga2host_arbiter

Packet-level arbiter that shares the single FPGA-to-host stream of the SPI front end between several on-chip producers (capture engine, command replies, status reports). It grants one source at a time for a whole packet and prefixes each packet with a header word identifying the source and a sequence number. It enforces a maximum packet length, truncating and draining overlong packets. It sits directly in front of the `spi_interface` fpga2host AXI stream input.

## Interface
- `NUM_SRC`, 3: number of producer ports (2..8).
- `MAX_PKT_WORDS`, 256: maximum data words per packet, header excluded.
- `HDR_TAG`, 8'hA5: constant placed in header bits [31:24].
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `s_tvalid`  in  NUM_SRC  per-source word valid.
- `s_tdata`  in  NUM_SRC×32  per-source word data, packed array.
- `s_tlast`  in  NUM_SRC  per-source end of packet.
- `s_tready`  out  NUM_SRC  per-source accept.
- `m_tvalid`  out  1  output word valid, toward the fpga2host stream.
- `m_tdata`  out  32  output word.
- `m_tlast`  out  1  output end of packet.
- `m_tready`  in  1  downstream accept.
- `err_trunc_pulse`  out  1  one-cycle pulse when a packet is truncated.

## Operation
- States are IDLE, HDR, DATA and DROP.
- **IDLE:** when any `s_tvalid` is high, grant the lowest index at or after `rr_ptr`, cyclically, and go to HDR. If no source is valid, stay in IDLE.
- **HDR:** when the output slot is free, load the header into the output register and go to DATA.
  - Header layout: {HDR_TAG, 8-bit source index, 16-bit `seq`}.
  - `seq` increments after the header is loaded and wraps 16'hFFFF→0.
- **DATA:** pass the granted source's words through.
  - `s_tready[g]` = (state==DATA) && slot free; all other `s_tready` bits are 0.
  - On an accepted word with `s_tlast`, forward it with `m_tlast`=1, set `rr_ptr`=g+1 mod NUM_SRC, and go to IDLE.
  - On the accepted word where `wcnt`==MAX_PKT_WORDS-1 without `s_tlast`, forward it with `m_tlast` forced to 1 and pulse `err_trunc_pulse`. Then go to DROP.
- **DROP:** hold `s_tready[g]`=1 and discard words. When `s_tlast` is accepted, update `rr_ptr` and go to IDLE.
- `wcnt` counts accepted data words. Width is $clog2(MAX_PKT_WORDS+1). It is cleared in IDLE.
- A source is never granted mid-packet of another. A source deasserting `s_tvalid` mid-packet stalls the output and does not release the grant.

## Timing
- The output register is the single stage. Slot free = !m_tvalid || m_tready, which gives full throughput of 1 word/cycle.
- Latency:
  - Source valid in IDLE → header on `m_tvalid` after 2 cycles.
  - Source word accepted → appears on `m_*` the next cycle.
- Packet overhead: 2 cycles. The IDLE decision cycle and the HDR cycle are both bubbles on the source side. Back-to-back packets therefore cost 2 cycles between the last data word and the next header.
- `m_tdata`, `m_tlast` and `m_tvalid` are stable while `m_tvalid`=1 and `m_tready`=0.
- Reset values:
  - `m_tvalid`, `m_tlast`, `m_tdata`, `s_tready`, `err_trunc_pulse` = 0.
  - state=IDLE, `rr_ptr`=0, `seq`=0, `wcnt`=0.
- Reset mid-packet drops the output word and any partial packet. No `m_tlast` is emitted.
- Simultaneous truncation and `s_tlast` on the same word counts as a normal end of packet. There is no pulse and no DROP.

## Configuration
- `FPGA2HOST_ARB_PRIO_EN` defined: source 0 has strict priority in IDLE, and sources 1..NUM_SRC-1 round-robin among themselves. `rr_ptr` is never set to 0.
- Undefined: plain round-robin over all sources.

## Structure
- Shared package `fpga2host_pkg` holds:
  - the header field positions and the `HDR_TAG` default;
  - the state enum `arb_state_t`;
  - the `WORD_W`=32 constant.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are the request vector and pointer; outputs are the grant index and a found flag. It is reused by the priority variant with a masked request.

## Test plan
- **Single packet:** src1 sends 3 words 0x11,0x22,0x33 (last on 0x33).
  - Required output: 0xA5010000, 0x11, 0x22, 0x33.
  - `m_tlast` only on 0x33; the next header carries seq=0x0001.
- **Round robin:** all 3 sources hold a 1-word packet pending continuously. Required grant order is 0,1,2,0.
  - With `FPGA2HOST_ARB_PRIO_EN`, src0 repeatedly valid gives grants 0,0,0 and the others are starved.
- **Backpressure:** `m_tready` toggles 1010… during a 4-word packet.
  - No word is lost or duplicated, data is held while stalled, and `s_tready` stays low while the slot is full.
- **Truncation:** MAX_PKT_WORDS=4, src2 sends 6 words.
  - Output is the header plus 4 words, `m_tlast` on the 4th, and `err_trunc_pulse` for 1 cycle.
  - Words 5–6 are consumed and not forwarded. The next packet proceeds normally.
- **Exact length:** 4 words with `s_tlast` on the 4th. Required: no pulse, no DROP.
- **Reset mid-packet:** assert `rst` after 2 data words.
  - The next cycle shows `m_tvalid`=0 and state IDLE.
  - A new packet gets a header with seq=0 and the src0 grant first.
